jtag_stream_sched: RTL and testbench

JTAG_STREAM_SCHED -- requirements
Module: jtag_stream_sched

---
 rtl/jtag_stream_sched.sv | 180 ++++++++++++++++++
 tb/tb_jtag_stream_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/jtag_stream_sched.sv
// jtag_stream_sched: arbitrates two byte streams onto a JTAG player FIFO.
// Ports: req/valid/data/last/ready/grant per requester A/B; FIFO write
// port data_in/write_enable_fifo; player status full/empty/error/eof and
// wr_data_count; rst_player pulse; clr_err/busy/done/err/err_code/byte_cnt.
module jtag_stream_sched #(
    parameter int FULL_THRESH   = 1016,
    parameter int DRAIN_TIMEOUT = 65535
) (
    input  logic       clk_in,
    input  logic       rst_fifo,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       valid_a,
    input  logic       valid_b,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    input  logic       last_a,
    input  logic       last_b,
    output logic       ready_a,
    output logic       ready_b,
    output logic       grant_a,
    output logic       grant_b,
    output logic [7:0] data_in,
    output logic       write_enable_fifo,
    input  logic       full_fifo,
    input  logic       empty_fifo,
    input  logic       error_out,
    input  logic       eof_out,
    input  logic [9:0] wr_data_count,
    output logic       rst_player,
    input  logic       clr_err,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [15:0] byte_cnt
);

    localparam logic [9:0]  FULL_LVL = 10'(FULL_THRESH);
    localparam logic [15:0] TMO_LAST = 16'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, STREAM, DRAIN, DONE, ERR
    } state_t;

    state_t      state_q, state_d;
    logic        grant_a_q, grant_a_d;
    logic        grant_b_q, grant_b_d;
    logic        owner_q, owner_d;   // 1 = B owns the current packet
    logic        ptr_q, ptr_d;       // 1 = B wins the next tie
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  data_q;
    logic        we_q;

    logic        room;
    logic        accept;
    logic        last_sel;
    logic [7:0]  data_sel;
    logic        pick_b;

    // error_out gates ready combinationally so a byte racing an error
    // is never written.
    assign room     = !full_fifo && (wr_data_count < FULL_LVL) && !error_out;
    assign ready_a  = (state_q == STREAM) && grant_a_q && room;
    assign ready_b  = (state_q == STREAM) && grant_b_q && room;
    assign accept   = (ready_a && valid_a) || (ready_b && valid_b);
    assign last_sel = owner_q ? last_b : last_a;
    assign data_sel = owner_q ? data_b : data_a;

    assign grant_a           = grant_a_q;
    assign grant_b           = grant_b_q;
    assign data_in           = data_q;
    assign write_enable_fifo = we_q;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign err               = (state_q == ERR);
    assign err_code          = code_q;
    assign byte_cnt          = cnt_q;
    assign rst_player        = rst_fifo || ((state_q == ERR) && clr_err);

    always_comb begin
        state_d   = state_q;
        grant_a_d = grant_a_q;
        grant_b_d = grant_b_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        code_d    = code_q;
        pick_b    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_a || req_b) begin
                    pick_b    = req_b && (!req_a || ptr_q);
                    grant_a_d = !pick_b;
                    grant_b_d = pick_b;
                    owner_d   = pick_b;
                    cnt_d     = '0;
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (error_out) begin
                    state_d   = ERR;
                    code_d    = 2'd1;
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                end else if (accept) begin
                    if (cnt_q != 16'hFFFF)
                        cnt_d = cnt_q + 16'd1;
                    if (last_sel) begin
                        state_d = DRAIN;
                        tmo_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (error_out) begin
                    state_d   = ERR;
                    code_d    = 2'd1;
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                end else if (empty_fifo && eof_out) begin
                    state_d   = DONE;
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ERR;
                    code_d    = 2'd2;
                    grant_a_d = 1'b0;
                    grant_b_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            DONE: begin
                ptr_d   = !owner_q;
                state_d = IDLE;
            end
            ERR: begin
                if (clr_err) begin
                    code_d  = '0;
                    ptr_d   = !owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_fifo) begin
            state_q   <= IDLE;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            code_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            code_q    <= code_d;
            we_q      <= accept;
            if (accept)
                data_q <= data_sel;
        end
    end

endmodule

// File: tb/tb_jtag_stream_sched.sv
// tb_jtag_stream_sched: directed bench for jtag_stream_sched.
// Walks arbitration, throttling, error, drain timeout and reset cases.
module tb_jtag_stream_sched;

    logic        clk_in = 1'b0;
    logic        rst_fifo;
    logic        req_a, req_b, valid_a, valid_b, last_a, last_b;
    logic [7:0]  data_a, data_b;
    logic        ready_a, ready_b, grant_a, grant_b;
    logic [7:0]  data_in;
    logic        write_enable_fifo;
    logic        full_fifo, empty_fifo, error_out, eof_out;
    logic [9:0]  wr_data_count;
    logic        rst_player, clr_err, busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] byte_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    jtag_stream_sched #(
        .FULL_THRESH(1016),
        .DRAIN_TIMEOUT(16)
    ) dut (
        .clk_in(clk_in), .rst_fifo(rst_fifo),
        .req_a(req_a), .req_b(req_b),
        .valid_a(valid_a), .valid_b(valid_b),
        .data_a(data_a), .data_b(data_b),
        .last_a(last_a), .last_b(last_b),
        .ready_a(ready_a), .ready_b(ready_b),
        .grant_a(grant_a), .grant_b(grant_b),
        .data_in(data_in), .write_enable_fifo(write_enable_fifo),
        .full_fifo(full_fifo), .empty_fifo(empty_fifo),
        .error_out(error_out), .eof_out(eof_out),
        .wr_data_count(wr_data_count), .rst_player(rst_player),
        .clr_err(clr_err), .busy(busy), .done(done), .err(err),
        .err_code(err_code), .byte_cnt(byte_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input bit sel_b, input logic [7:0] d,
                        input bit last);
        if (sel_b) begin
            valid_b = 1'b1; data_b = d; last_b = last;
        end else begin
            valid_a = 1'b1; data_a = d; last_a = last;
        end
        #1;
        chk("send_ready", sel_b ? ready_b : ready_a, 1);
        tick();
        chk("send_we", write_enable_fifo, 1);
        chk("send_data", data_in, d);
        valid_a = 1'b0; valid_b = 1'b0;
        last_a  = 1'b0; last_b  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_fifo = 1; req_a = 0; req_b = 0; valid_a = 0; valid_b = 0;
        last_a = 0; last_b = 0; data_a = 0; data_b = 0;
        full_fifo = 0; empty_fifo = 0; error_out = 0; eof_out = 0;
        wr_data_count = 0; clr_err = 0;
        tick();
        tick();
        chk("rst_player_in_reset", rst_player, 1);
        chk("rst_busy", busy, 0);
        chk("rst_grants", {grant_a, grant_b}, 0);
        chk("rst_outs", {done, err, err_code, write_enable_fifo}, 0);
        chk("rst_cnt", byte_cnt, 0);

        // tie after reset: A first, 4-byte packet
        rst_fifo = 0; req_a = 1; req_b = 1;
        #1;
        chk("rst_player_low", rst_player, 0);
        tick();
        chk("tie_grant", {grant_a, grant_b}, 2'b10);
        chk("busy_stream", busy, 1);
        req_a = 0; req_b = 0;
        chk("ready_b_ungranted", ready_b, 0);
        send(0, 8'h11, 0);
        send(0, 8'h12, 0);
        send(0, 8'h13, 0);
        send(0, 8'h14, 1);
        chk("cnt4", byte_cnt, 4);
        chk("drain_ready", ready_a, 0);
        tick();
        chk("drain_no_we", write_enable_fifo, 0);
        chk("drain_no_done", done, 0);
        empty_fifo = 1; eof_out = 1;
        tick();
        chk("done_pulse", done, 1);
        chk("done_grant_drop", {grant_a, grant_b}, 0);
        empty_fifo = 0; eof_out = 0;
        req_a = 1; req_b = 1;
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        tick();
        chk("rr_grant_b", {grant_a, grant_b}, 2'b01);
        req_a = 0; req_b = 0;

        // throttle at FULL_THRESH
        send(1, 8'h21, 0);
        wr_data_count = 10'd1016;
        valid_b = 1; data_b = 8'h22;
        #1;
        chk("thresh_ready", ready_b, 0);
        tick();
        chk("thresh_no_we", write_enable_fifo, 0);
        wr_data_count = 10'd1015;
        send(1, 8'h22, 0);
        chk("thresh_cnt", byte_cnt, 2);
        wr_data_count = 0;

        // full_fifo also stalls
        full_fifo = 1;
        #1;
        chk("full_ready", ready_b, 0);
        full_fifo = 0;

        // error_out collides with last
        valid_b = 1; data_b = 8'h23; last_b = 1; error_out = 1;
        #1;
        chk("err_ready_drop", ready_b, 0);
        tick();
        chk("err_set", err, 1);
        chk("err_code1", err_code, 1);
        chk("err_no_done", done, 0);
        chk("err_no_we", write_enable_fifo, 0);
        chk("err_grants", {grant_a, grant_b}, 0);
        valid_b = 0; last_b = 0; error_out = 0;
        tick();
        chk("err_held", err, 1);
        clr_err = 1;
        #1;
        chk("clr_rst_player", rst_player, 1);
        tick();
        clr_err = 0;
        #1;
        chk("clr_rst_player_1cyc", rst_player, 0);
        chk("clr_err", {err, err_code}, 0);
        chk("clr_idle", busy, 0);

        // drain timeout
        req_a = 1;
        tick();
        chk("to_grant_a", {grant_a, grant_b}, 2'b10);
        req_a = 0;
        send(0, 8'hA5, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("to_err", err, (i == 16) ? 1 : 0);
        end
        chk("to_code2", err_code, 2);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("to_clr", {err, busy}, 0);

        // reset mid-packet; pointer now favours B
        req_a = 1; req_b = 1;
        tick();
        chk("pre_rst_grant_b", {grant_a, grant_b}, 2'b01);
        req_a = 0; req_b = 0;
        send(1, 8'h33, 0);
        rst_fifo = 1;
        tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_grants", {grant_a, grant_b, ready_a, ready_b}, 0);
        chk("mid_rst_outs", {done, err, err_code, write_enable_fifo}, 0);
        chk("mid_rst_data", data_in, 0);
        chk("mid_rst_cnt", byte_cnt, 0);
        chk("mid_rst_player", rst_player, 1);
        rst_fifo = 0; req_a = 1; req_b = 1;
        tick();
        chk("post_rst_tie", {grant_a, grant_b}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
